// File: rtl/hazard_stall_ctrl_if.sv
// Signal bundle between the pipeline datapath and the hazard/stall controller.
// The datapath side drives hazard information and consumes the register controls.
interface hazard_stall_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       RegRs_ID;
    logic [4:0]       RegRt_ID;
    logic             UsesRt_ID;
    logic             MfHiLo_ID;
    logic [4:0]       RegRt_EX;
    logic             MemRd_EX;
    logic             MdStart_EX;
    logic             BrTaken_EX;
    logic             DmemReq_MEM;
    logic             DmemRdy;

    logic             PcEn;
    logic             IfIdEn;
    logic             IfIdFlush;
    logic             IdExEn;
    logic             IdExFlush;
    logic             ExMemEn;
    logic             MdBusy;
    logic [CNT_W-1:0] StallCnt;

    modport master (
        output RegRs_ID, RegRt_ID, UsesRt_ID, MfHiLo_ID, RegRt_EX, MemRd_EX,
               MdStart_EX, BrTaken_EX, DmemReq_MEM, DmemRdy,
        input  PcEn, IfIdEn, IfIdFlush, IdExEn, IdExFlush, ExMemEn, MdBusy, StallCnt
    );

    modport slave (
        input  RegRs_ID, RegRt_ID, UsesRt_ID, MfHiLo_ID, RegRt_EX, MemRd_EX,
               MdStart_EX, BrTaken_EX, DmemReq_MEM, DmemRdy,
        output PcEn, IfIdEn, IfIdFlush, IdExEn, IdExFlush, ExMemEn, MdBusy, StallCnt
    );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// Pipeline sequencing controller: resolves memory-wait, redirect, HI/LO-behind-mult/div
// and load-use hazards into PC / pipeline-register enables and flushes.
module hazard_stall_ctrl #(
    parameter int MD_LAT = 32,
    parameter int CNT_W  = 16
) (
    input  logic                 clk,
    input  logic                 rstb,
    hazard_stall_ctrl_if.slave   bus
);

    typedef enum logic [1:0] {
        ACT_RUN,
        ACT_FREEZE,
        ACT_FLUSH,
        ACT_BUBBLE
    } action_e;

    localparam logic [5:0] MD_RELOAD = 6'(MD_LAT - 1);

    logic [5:0]       mdCnt_q, mdCnt_d;
    logic             mdBusy_q;
    logic [CNT_W-1:0] stallCnt_q, stallCnt_d;

    logic    memWait, redirect, hiLoWait, loadUse;
    action_e action;
    logic    pcEn, ifIdEn, ifIdFlush, idExEn, idExFlush, exMemEn;

    // Hazard detection; $0 is hardwired zero so a load into it never creates a dependency.
    always_comb begin
        memWait  = bus.DmemReq_MEM & ~bus.DmemRdy;
        redirect = bus.BrTaken_EX;
        hiLoWait = bus.MfHiLo_ID & (mdCnt_q != 6'd0);
        loadUse  = bus.MemRd_EX & (bus.RegRt_EX != 5'd0) &
                   ((bus.RegRt_EX == bus.RegRs_ID) |
                    (bus.UsesRt_ID & (bus.RegRt_EX == bus.RegRt_ID)));
    end

    // Strict priority: a frozen pipe beats everything, and a redirect squashes the
    // ID instruction so any stall it would have caused is moot.
    always_comb begin
        action = ACT_RUN;
        if (memWait) begin
            action = ACT_FREEZE;
        end else if (redirect) begin
            action = ACT_FLUSH;
        end else if (hiLoWait | loadUse) begin
            action = ACT_BUBBLE;
        end
    end

    always_comb begin
        pcEn      = 1'b1;
        ifIdEn    = 1'b1;
        ifIdFlush = 1'b0;
        idExEn    = 1'b1;
        idExFlush = 1'b0;
        exMemEn   = 1'b1;
        unique case (action)
            ACT_FREEZE: begin
                pcEn    = 1'b0;
                ifIdEn  = 1'b0;
                idExEn  = 1'b0;
                exMemEn = 1'b0;
            end
            ACT_FLUSH: begin
                ifIdFlush = 1'b1;
                idExFlush = 1'b1;
            end
            ACT_BUBBLE: begin
                pcEn      = 1'b0;
                ifIdEn    = 1'b0;
                idExFlush = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // While reset is held the pipe must load NOPs and never advance.
    always_comb begin
        bus.PcEn      = pcEn      & rstb;
        bus.IfIdEn    = ifIdEn    & rstb;
        bus.IfIdFlush = ifIdFlush | ~rstb;
        bus.IdExEn    = idExEn    & rstb;
        bus.IdExFlush = idExFlush | ~rstb;
        bus.ExMemEn   = exMemEn   & rstb;
        bus.MdBusy    = mdBusy_q;
        bus.StallCnt  = stallCnt_q;
    end

    always_comb begin
        mdCnt_d = mdCnt_q;
        if (!memWait) begin
            if (bus.MdStart_EX) begin
                mdCnt_d = MD_RELOAD;
            end else if (mdCnt_q != 6'd0) begin
                mdCnt_d = mdCnt_q - 6'd1;
            end
        end
    end

    always_comb begin
        stallCnt_d = stallCnt_q;
        if (!pcEn && (stallCnt_q != {CNT_W{1'b1}})) begin
            stallCnt_d = stallCnt_q + CNT_W'(1);
        end
    end

    // MdBusy is registered from the next count so it tracks mdCnt_q exactly.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            mdCnt_q    <= 6'd0;
            mdBusy_q   <= 1'b0;
            stallCnt_q <= '0;
        end else begin
            mdCnt_q    <= mdCnt_d;
            mdBusy_q   <= (mdCnt_d != 6'd0);
            stallCnt_q <= stallCnt_d;
        end
    end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl: a default-parameter instance for the main hazard
// scenarios and a small one (MD_LAT=2, CNT_W=3) for latency minimum and counter saturation.
module tb_hazard_stall_ctrl;

    localparam logic [5:0] CTL_RUN    = 6'b110101;
    localparam logic [5:0] CTL_FREEZE = 6'b000000;
    localparam logic [5:0] CTL_FLUSH  = 6'b111111;
    localparam logic [5:0] CTL_BUBBLE = 6'b000111;
    localparam logic [5:0] CTL_RESET  = 6'b001010;

    logic clk;
    logic rstb;
    int   cmpCnt;
    int   errCnt;

    hazard_stall_ctrl_if #(.CNT_W(16)) m ();
    hazard_stall_ctrl_if #(.CNT_W(3))  s ();

    hazard_stall_ctrl #(.MD_LAT(32), .CNT_W(16)) dut (
        .clk  (clk),
        .rstb (rstb),
        .bus  (m.slave)
    );

    hazard_stall_ctrl #(.MD_LAT(2), .CNT_W(3)) dutSmall (
        .clk  (clk),
        .rstb (rstb),
        .bus  (s.slave)
    );

    logic [5:0] ctlM;
    logic [5:0] ctlS;
    assign ctlM = {m.PcEn, m.IfIdEn, m.IfIdFlush, m.IdExEn, m.IdExFlush, m.ExMemEn};
    assign ctlS = {s.PcEn, s.IfIdEn, s.IfIdFlush, s.IdExEn, s.IdExFlush, s.ExMemEn};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic applyStimulus(input logic [4:0] rs, input logic [4:0] rt, input logic usesRt,
                                 input logic mfHiLo, input logic [4:0] rtEx, input logic memRd,
                                 input logic mdStart, input logic brTaken, input logic memWait);
        m.RegRs_ID    = rs;
        m.RegRt_ID    = rt;
        m.UsesRt_ID   = usesRt;
        m.MfHiLo_ID   = mfHiLo;
        m.RegRt_EX    = rtEx;
        m.MemRd_EX    = memRd;
        m.MdStart_EX  = mdStart;
        m.BrTaken_EX  = brTaken;
        m.DmemReq_MEM = memWait;
        m.DmemRdy     = ~memWait;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        cmpCnt++;
        assert (obs === exp) else begin
            errCnt++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        int stalls;
        int guard;
        logic busyLast;
        logic done;

        cmpCnt = 0;
        errCnt = 0;
        rstb   = 1'b1;
        applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        s.RegRs_ID = 5'd0; s.RegRt_ID = 5'd0; s.UsesRt_ID = 1'b0; s.MfHiLo_ID = 1'b0;
        s.RegRt_EX = 5'd0; s.MemRd_EX = 1'b0; s.MdStart_EX = 1'b0; s.BrTaken_EX = 1'b0;
        s.DmemReq_MEM = 1'b0; s.DmemRdy = 1'b1;

        // Reset holds the pipe in flush with counters cleared
        #2 rstb = 1'b0;
        #1;
        checkOutput("reset_ctl", 32'(ctlM), 32'(CTL_RESET));
        checkOutput("reset_busy", 32'(m.MdBusy), 32'd0);
        checkOutput("reset_cnt", 32'(m.StallCnt), 32'd0);

        @(negedge clk);
        rstb = 1'b1;
        #1;
        checkOutput("idle_ctl", 32'(ctlM), 32'(CTL_RUN));

        // Load-use through rs
        @(negedge clk);
        applyStimulus(5'd5, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
        #1;
        checkOutput("lu_rs_ctl", 32'(ctlM), 32'(CTL_BUBBLE));
        @(negedge clk);
        checkOutput("lu_rs_cnt", 32'(m.StallCnt), 32'd1);

        // Load into $0 never stalls
        applyStimulus(5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        #1;
        checkOutput("lu_r0_ctl", 32'(ctlM), 32'(CTL_RUN));

        // rt only matters when the ID instruction reads it
        @(negedge clk);
        checkOutput("lu_r0_cnt", 32'(m.StallCnt), 32'd1);
        applyStimulus(5'd3, 5'd7, 1'b0, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
        #1;
        checkOutput("rt_unused_ctl", 32'(ctlM), 32'(CTL_RUN));
        @(negedge clk);
        applyStimulus(5'd3, 5'd7, 1'b1, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
        #1;
        checkOutput("rt_used_ctl", 32'(ctlM), 32'(CTL_BUBBLE));
        @(negedge clk);
        checkOutput("rt_used_cnt", 32'(m.StallCnt), 32'd2);

        // Taken branch overrides a simultaneous load-use
        applyStimulus(5'd3, 5'd7, 1'b1, 1'b0, 5'd7, 1'b1, 1'b0, 1'b1, 1'b0);
        #1;
        checkOutput("br_lu_ctl", 32'(ctlM), 32'(CTL_FLUSH));
        @(negedge clk);
        checkOutput("br_lu_cnt", 32'(m.StallCnt), 32'd2);

        // Mult/div issue then MFHI held: 31 stall cycles
        applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        #1;
        checkOutput("md_issue_ctl", 32'(ctlM), 32'(CTL_RUN));
        @(negedge clk);
        applyStimulus(5'd0, 5'd0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        checkOutput("md_busy_set", 32'(m.MdBusy), 32'd1);
        stalls   = 0;
        guard    = 0;
        busyLast = 1'b0;
        while ((ctlM == CTL_BUBBLE) && (guard < 100)) begin
            stalls++;
            busyLast = m.MdBusy;
            @(negedge clk);
            #1;
            guard++;
        end
        checkOutput("md_stalls", 32'(stalls), 32'd31);
        checkOutput("md_busy_last_stall", 32'(busyLast), 32'd1);
        checkOutput("md_release_busy", 32'(m.MdBusy), 32'd0);
        checkOutput("md_release_ctl", 32'(ctlM), 32'(CTL_RUN));
        checkOutput("md_cnt", 32'(m.StallCnt), 32'd33);

        // Memory wait in the middle of a countdown freezes it: 31 + 5 cycles with PcEn low
        @(negedge clk);
        applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        stalls = 0;
        guard  = 0;
        done   = 1'b0;
        while (!done && (guard < 200)) begin
            applyStimulus(5'd0, 5'd0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0,
                          (stalls >= 3) && (stalls < 8));
            #1;
            if (stalls == 3) checkOutput("mw_ctl", 32'(ctlM), 32'(CTL_FREEZE));
            if (m.PcEn) begin
                done = 1'b1;
            end else begin
                stalls++;
                @(negedge clk);
            end
            guard++;
        end
        checkOutput("mw_md_stalls", 32'(stalls), 32'd36);
        checkOutput("mw_md_busy", 32'(m.MdBusy), 32'd0);
        @(negedge clk);
        checkOutput("mw_md_cnt", 32'(m.StallCnt), 32'd69);

        // Reset in the middle of a countdown abandons it
        applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        applyStimulus(5'd0, 5'd0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("pre_rst_busy", 32'(m.MdBusy), 32'd1);
        #2 rstb = 1'b0;
        #1;
        checkOutput("mid_rst_busy", 32'(m.MdBusy), 32'd0);
        checkOutput("mid_rst_cnt", 32'(m.StallCnt), 32'd0);
        checkOutput("mid_rst_ctl", 32'(ctlM), 32'(CTL_RESET));
        @(negedge clk);
        rstb = 1'b1;
        #1;
        checkOutput("post_rst_hilo_ctl", 32'(ctlM), 32'(CTL_RUN));
        @(negedge clk);
        checkOutput("post_rst_cnt", 32'(m.StallCnt), 32'd0);
        applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Minimum latency instance: MD_LAT=2 gives a single HI/LO stall cycle
        s.MdStart_EX = 1'b1;
        @(negedge clk);
        s.MdStart_EX = 1'b0;
        s.MfHiLo_ID  = 1'b1;
        #1;
        checkOutput("lat2_stall_ctl", 32'(ctlS), 32'(CTL_BUBBLE));
        @(negedge clk);
        #1;
        checkOutput("lat2_release_ctl", 32'(ctlS), 32'(CTL_RUN));
        checkOutput("lat2_cnt", 32'(s.StallCnt), 32'd1);

        // Saturation of the 3-bit counter after 1 + 9 stall cycles
        s.MfHiLo_ID   = 1'b0;
        s.DmemReq_MEM = 1'b1;
        s.DmemRdy     = 1'b0;
        for (int i = 0; i < 9; i++) @(negedge clk);
        checkOutput("sat_cnt", 32'(s.StallCnt), 32'd7);
        @(negedge clk);
        checkOutput("sat_hold_cnt", 32'(s.StallCnt), 32'd7);
        s.DmemReq_MEM = 1'b0;
        s.DmemRdy     = 1'b1;
        #1;
        checkOutput("sat_run_ctl", 32'(ctlS), 32'(CTL_RUN));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCnt, errCnt);
        $finish;
    end

endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
Pipeline sequencing controller for the MIPS32 five-stage pipelined core. It generates the PC and pipeline-register enable and flush controls. It covers the hazards that operand forwarding cannot resolve: load-use, data-memory wait, taken branch/jump redirect, and HI/LO reads behind a multi-cycle multiply/divide. It sits beside the forwarding unit and drives the IF/ID, ID/EX and EX/MEM register controls.

Parameters:
MD_LAT, 32, EX-stage occupancy of a mult/div in cycles (legal 2..63)
CNT_W, 16, width of the saturating stall-cycle performance counter

Ports:
clk  input  1  clock, rising edge
rstb  input  1  asynchronous active-low reset
RegRs_ID  input  5  rs of instruction in ID
RegRt_ID  input  5  rt of instruction in ID
UsesRt_ID  input  1  ID instruction reads rt as a source
MfHiLo_ID  input  1  ID instruction is MFHI/MFLO
RegRt_EX  input  5  load destination register in EX
MemRd_EX  input  1  EX instruction is a load
MdStart_EX  input  1  mult/div issues in EX this cycle (single-cycle pulse)
BrTaken_EX  input  1  branch/jump resolved taken in EX
DmemReq_MEM  input  1  MEM stage has a data-memory access
DmemRdy  input  1  data memory accepts/completes the access this cycle
PcEn  output  1  PC register update enable
IfIdEn  output  1  IF/ID register enable
IfIdFlush  output  1  IF/ID load NOP
IdExEn  output  1  ID/EX register enable
IdExFlush  output  1  ID/EX load bubble
ExMemEn  output  1  EX/MEM and MEM/WB register enable
MdBusy  output  1  mult/div countdown active
StallCnt  output  CNT_W  cycles with PcEn=0, saturating

Behaviour:
- Reset (rstb=0, async): MdCnt=0, StallCnt=0. All enables are forced to 0, all flushes to 1, and MdBusy=0 while rstb is low. Mid-operation reset abandons any countdown.
- Conditions, evaluated each cycle:
  - MW = DmemReq_MEM & ~DmemRdy
  - BR = BrTaken_EX
  - MD = MfHiLo_ID & (MdCnt != 0)
  - LU = MemRd_EX & RegRt_EX != 0 & (RegRt_EX == RegRs_ID | (UsesRt_ID & RegRt_EX == RegRt_ID))
- Strict priority, first true condition wins:
  - MW: all enables 0, no flush. Whole pipe freezes and MdCnt holds.
  - BR: PcEn=1, IfIdEn=1, IfIdFlush=1, IdExEn=1, IdExFlush=1, ExMemEn=1. BR overrides MD/LU because the ID instruction is squashed.
  - MD or LU: PcEn=0, IfIdEn=0, IdExEn=1, IdExFlush=1, ExMemEn=1. A bubble is inserted into EX.
  - None: all enables 1, no flush.
- Output timing: enables and flushes are combinational from the inputs and MdCnt, with zero latency.
- MdCnt (6-bit) update rules, applied on a rising clock edge when not in MW:
  - MdStart_EX=1 loads MD_LAT-1.
  - Otherwise, if nonzero, it decrements.
  - MdStart_EX while MdCnt != 0 reloads MD_LAT-1 (restart).
- MdBusy = (MdCnt != 0), registered.
- LU lasts exactly one cycle: the next cycle the load is in MEM and the forwarding unit covers it. The controller does not hold LU state.
- StallCnt increments on every cycle where PcEn=0 and rstb=1. It saturates at 2^CNT_W-1 and does not wrap.
- Register $0 never triggers LU.

Test Plan:
- Load-use: MemRd_EX=1, RegRt_EX=5, RegRs_ID=5 -> one cycle with PcEn=0, IfIdEn=0, IdExFlush=1, StallCnt 0->1. With RegRt_EX=0 -> no stall.
- rt gating: RegRt_EX=7, RegRt_ID=7, UsesRt_ID=0 -> no stall. With UsesRt_ID=1 -> stall.
- Mult/div: MdStart_EX pulse with MD_LAT=32, then MfHiLo_ID=1 held -> stall exactly 31 cycles. MdBusy falls the same cycle the stall releases.
- Memory wait during MD countdown: DmemRdy=0 for 5 cycles with DmemReq_MEM=1 -> all enables 0 and MdCnt frozen. Total HI/LO stall is 31+5 cycles.
- Branch vs load-use: BrTaken_EX=1 and LU true simultaneously -> IfIdFlush=1, IdExFlush=1, PcEn=1, StallCnt unchanged.
- Reset: assert rstb low mid-countdown -> MdBusy=0, StallCnt=0 immediately. After release, MfHiLo_ID does not stall.
